counter_rtl: RTL and testbench

Synchronous 4-bit modulo-12 up/down counter with parallel load. Count values run 0 to 11. The counter advances every clock and can be preloaded from `data_in`. It is driven through the `counter_if` signal bundle, which carries `clock` as its port and `reset`, `load`, `data_in`, `upd` and `count` as members. The block sits as the DUV under the layered counter test environment.

---
 rtl/counter_if.sv | 14 +
 rtl/counter_rtl.sv | 36 +++
 tb/tb_counter_rtl.sv | 118 +++++++++++
 3 files changed

// File: rtl/counter_if.sv
// Signal bundle for the modulo-12 counter: the clock is the interface port,
// everything else travels as members.
interface counter_if (
  input logic clock
);
  logic       reset;
  logic       load;
  logic [3:0] data_in;
  logic       upd;
  logic [3:0] count;

  modport master (input clock, output reset, output load, output data_in, output upd, input count);
  modport slave  (input clock, input reset, input load, input data_in, input upd, output count);
endinterface

// File: rtl/counter_rtl.sv
// 4-bit modulo-12 up/down counter with synchronous parallel load and
// asynchronous active-low reset; count is driven straight from the register.
module counter_rtl (
  counter_if.slave cif
);
  localparam logic [3:0] COUNT_MAX = 4'd11;

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = '0;
    if (cif.load) begin
      count_d = (cif.data_in > COUNT_MAX) ? '0 : cif.data_in;
    end else if (count_q > COUNT_MAX) begin
      // Unreachable in normal operation; recovers an upset register to 0.
      count_d = '0;
    end else if (cif.upd) begin
      count_d = (count_q == COUNT_MAX) ? '0 : count_q + 4'd1;
    end else begin
      count_d = (count_q == 4'd0) ? COUNT_MAX : count_q - 4'd1;
    end
  end

  // NOTE: non-blocking assignment for state so all flops update together at the edge.
  always_ff @(posedge cif.clock or negedge cif.reset) begin
    if (!cif.reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cif.count = count_q;
endmodule

// File: tb/tb_counter_rtl.sv
// Self-checking bench for counter_rtl: directed vector table, reset and
// multi-cycle corner sequences, then a randomized run against a modular model.
module tb_counter_rtl;
  logic clock;
  int   checks;
  int   failures;
  int   model;

  typedef struct {
    logic       load;
    logic [3:0] data_in;
    logic       upd;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  counter_if bus (.clock(clock));
  counter_rtl dut (.cif(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic l, input logic [3:0] d, input logic u, input logic [3:0] e,
                     input string name);
    vec_t v;
    v.load = l; v.data_in = d; v.upd = u; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  // Called at a falling edge; applies inputs, checks after the rising edge,
  // and returns at the next falling edge.
  task automatic step(input logic l, input logic [3:0] d, input logic u, input int e,
                      input string name);
    bus.load = l; bus.data_in = d; bus.upd = u;
    @(posedge clock);
    #1 check(name, bus.count, e);
    @(negedge clock);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.reset = 1'b0; bus.load = 1'b0; bus.data_in = 4'd0; bus.upd = 1'b1;

    repeat (2) @(posedge clock);
    #1 check("reset_state", bus.count, 0);

    // Release away from the edge, load 7, then assert reset mid-cycle.
    @(negedge clock);
    bus.reset = 1'b1;
    step(1'b1, 4'd7, 1'b1, 7, "load_7");
    @(posedge clock);
    #2;
    bus.reset = 1'b0; bus.load = 1'b1; bus.data_in = 4'd5;
    #1 check("async_reset", bus.count, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 check("reset_hold_load", bus.count, 0);
    end
    @(negedge clock);
    bus.reset = 1'b1;

    // Directed table from count = 0.
    for (int i = 1; i <= 14; i++) add(1'b0, 4'd0, 1'b1, 4'(i % 12), "up_wrap");
    add(1'b1, 4'd2, 1'b1, 4'd2, "load_2");
    add(1'b0, 4'd0, 1'b0, 4'd1, "down_1");
    add(1'b0, 4'd0, 1'b0, 4'd0, "down_0");
    add(1'b0, 4'd0, 1'b0, 4'd11, "down_wrap");
    add(1'b0, 4'd0, 1'b0, 4'd10, "down_10");
    add(1'b1, 4'd9, 1'b1, 4'd9, "load_prio");
    add(1'b0, 4'd9, 1'b1, 4'd10, "after_load_up");
    add(1'b1, 4'd14, 1'b1, 4'd0, "load_oor_14");
    add(1'b0, 4'd0, 1'b1, 4'd1, "oor_then_up");
    add(1'b1, 4'd3, 1'b0, 4'd3, "b2b_load_3");
    add(1'b1, 4'd11, 1'b0, 4'd11, "b2b_load_11");
    add(1'b1, 4'd15, 1'b1, 4'd0, "b2b_load_15");
    add(1'b1, 4'd12, 1'b0, 4'd0, "b2b_load_12");
    add(1'b0, 4'd0, 1'b1, 4'd1, "dir_up");
    add(1'b0, 4'd0, 1'b0, 4'd0, "dir_down");
    add(1'b0, 4'd0, 1'b0, 4'd11, "dir_down_wrap");
    add(1'b0, 4'd0, 1'b1, 4'd0, "dir_up_wrap");
    foreach (vecs[i]) step(vecs[i].load, vecs[i].data_in, vecs[i].upd, vecs[i].exp, vecs[i].name);

    // Randomized run with occasional mid-cycle reset pulses.
    model = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        bus.reset = 1'b0;
        #1 model = 0;
        check("rand_async_reset", bus.count, model);
        #2 bus.reset = 1'b1;
      end
      bus.load    = ($urandom_range(0, 3) == 0);
      bus.data_in = 4'($urandom_range(0, 15));
      bus.upd     = 1'($urandom_range(0, 1));
      @(posedge clock);
      if (bus.load)     model = (bus.data_in < 12) ? int'(bus.data_in) : 0;
      else if (bus.upd) model = (model + 1) % 12;
      else              model = (model + 11) % 12;
      #1 check("rand_model", bus.count, model);
      check("rand_range", (bus.count <= 4'd11) ? 1 : 0, 1);
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
